// File: rtl/read_guard.sv
// read_guard: AXI read-channel watchdog.
// Tracks outstanding reads from the observed AR/R channels and gives each one
// a cycle budget. It also bounds how long AR may stall. When any budget is
// overrun it raises a sticky reset request and a one-cycle interrupt.
// Optional build macro READ_GUARD_PROT_CHECK_EN: flags R last beats whose ID
// matches no outstanding read (unmatched_o). Without it, unmatched_o is 0.

// One tracking entry: ID, cycle counter and budget for one outstanding read.
module read_guard_entry #(
    parameter int IdWidth  = 4,
    parameter int CntWidth = 12
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clear_i,
    input  logic                alloc_i,
    input  logic                free_i,
    input  logic                freeze_i,
    input  logic [IdWidth-1:0]  id_i,
    input  logic [CntWidth-1:0] budget_i,
    output logic                valid_o,
    output logic [IdWidth-1:0]  id_o,
    output logic [CntWidth-1:0] cnt_o,
    output logic                timed_out_o
);
    localparam logic [CntWidth-1:0] CntMax = '1;

    logic [CntWidth-1:0] budget_q;

    // Allocate, free or age the entry; the counter holds while a reset request is pending.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            valid_o  <= 1'b0;
            id_o     <= '0;
            cnt_o    <= '0;
            budget_q <= '0;
        end else if (alloc_i) begin
            valid_o  <= 1'b1;
            id_o     <= id_i;
            cnt_o    <= '0;
            budget_q <= budget_i;
        end else if (free_i) begin
            valid_o <= 1'b0;
        end else if (valid_o && !freeze_i && cnt_o != CntMax) begin
            cnt_o <= cnt_o + 1'b1;
        end
    end

    assign timed_out_o = valid_o && (cnt_o > budget_q);
endmodule

module read_guard #(
    parameter int MaxRdTxns = 8,
    parameter int IdWidth   = 4,
    parameter int CntWidth  = 12
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             ar_valid_i,
    input  logic                             ar_ready_i,
    input  logic [IdWidth-1:0]               ar_id_i,
    input  logic [7:0]                       ar_len_i,
    input  logic                             r_valid_i,
    input  logic                             r_ready_i,
    input  logic [IdWidth-1:0]               r_id_i,
    input  logic                             r_last_i,
    input  logic [7:0]                       budget_ar_i,
    input  logic [7:0]                       budget_base_i,
    input  logic [3:0]                       budget_beat_i,
    input  logic                             reset_clear_i,
    output logic                             reset_req_o,
    output logic                             irq_o,
    output logic                             overflow_o,
    output logic                             unmatched_o,
    output logic [$clog2(MaxRdTxns+1)-1:0]   txn_cnt_o,
    output logic [IdWidth-1:0]               timeout_id_o
);
    localparam int TxnW = $clog2(MaxRdTxns + 1);
    localparam int IdxW = (MaxRdTxns > 1) ? $clog2(MaxRdTxns) : 1;
    // The widest budget is 255 + 256*15 = 4095, so 14 bits never overflow.
    localparam logic [13:0] BudgetSat = (CntWidth >= 14) ? 14'h3fff
                                      : 14'((32'd1 << CntWidth) - 32'd1);

    logic [MaxRdTxns-1:0]               ent_valid, ent_to, alloc_vec, free_vec;
    logic [MaxRdTxns-1:0][IdWidth-1:0]  ent_id;
    logic [MaxRdTxns-1:0][CntWidth-1:0] ent_cnt;

    logic                ar_hs, r_last_hs, full, match, do_alloc, do_ret;
    logic [IdxW-1:0]     alloc_idx, ret_idx;
    logic [CntWidth-1:0] best_cnt;
    logic [13:0]         budget_calc, budget_sat;
    logic [CntWidth-1:0] budget_new;
    logic                ent_hit, detect, first_to;
    logic [IdWidth-1:0]  hit_id;
    logic [7:0]          stall_cnt;

    assign ar_hs     = ar_valid_i && ar_ready_i;
    assign r_last_hs = r_valid_i && r_ready_i && r_last_i;

    assign budget_calc = 14'(budget_base_i)
                       + (14'(ar_len_i) + 14'd1) * 14'(budget_beat_i);
    assign budget_sat  = (budget_calc > BudgetSat) ? BudgetSat : budget_calc;
    assign budget_new  = CntWidth'(budget_sat);

    // Lowest-index free entry; the table is full when none is free.
    always_comb begin
        full      = 1'b1;
        alloc_idx = '0;
        for (int i = MaxRdTxns - 1; i >= 0; i--) begin
            if (!ent_valid[i]) begin
                full      = 1'b0;
                alloc_idx = IdxW'(i);
            end
        end
    end

    // Oldest (largest counter) entry with the R ID; strict compare keeps ties at lowest index.
    always_comb begin
        match    = 1'b0;
        ret_idx  = '0;
        best_cnt = '0;
        for (int i = 0; i < MaxRdTxns; i++) begin
            if (ent_valid[i] && ent_id[i] == r_id_i && (!match || ent_cnt[i] > best_cnt)) begin
                match    = 1'b1;
                ret_idx  = IdxW'(i);
                best_cnt = ent_cnt[i];
            end
        end
    end

    // ID of the lowest-index timed-out entry; falls back to the stalled AR ID.
    always_comb begin
        ent_hit = 1'b0;
        hit_id  = ar_id_i;
        for (int i = MaxRdTxns - 1; i >= 0; i--) begin
            if (ent_to[i]) begin
                ent_hit = 1'b1;
                hit_id  = ent_id[i];
            end
        end
    end

    assign do_alloc = ar_hs && !full;
    assign do_ret   = r_last_hs && match;
    assign detect   = ent_hit || (stall_cnt > budget_ar_i);
    assign first_to = detect && !reset_req_o;

    // One-hot allocate/free strobes towards the entry array.
    always_comb begin
        alloc_vec = '0;
        free_vec  = '0;
        if (do_alloc) alloc_vec[alloc_idx] = 1'b1;
        if (do_ret)   free_vec[ret_idx]    = 1'b1;
    end

    for (genvar g = 0; g < MaxRdTxns; g++) begin : g_ent
        read_guard_entry #(
            .IdWidth  (IdWidth),
            .CntWidth (CntWidth)
        ) u_ent (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .clear_i     (reset_clear_i),
            .alloc_i     (alloc_vec[g]),
            .free_i      (free_vec[g]),
            .freeze_i    (reset_req_o),
            .id_i        (ar_id_i),
            .budget_i    (budget_new),
            .valid_o     (ent_valid[g]),
            .id_o        (ent_id[g]),
            .cnt_o       (ent_cnt[g]),
            .timed_out_o (ent_to[g])
        );
    end

    // AR stall counter: consecutive valid-without-ready cycles, frozen during a reset request.
    always_ff @(posedge clk_i) begin
        if (rst_i || reset_clear_i) begin
            stall_cnt <= '0;
        end else if (!ar_valid_i || ar_ready_i) begin
            stall_cnt <= '0;
        end else if (!reset_req_o && stall_cnt != 8'hff) begin
            stall_cnt <= stall_cnt + 8'd1;
        end
    end

    // Outstanding count tracks the table exactly: +1 per allocate, -1 per retire.
    always_ff @(posedge clk_i) begin
        if (rst_i || reset_clear_i) begin
            txn_cnt_o <= '0;
        end else begin
            txn_cnt_o <= txn_cnt_o + TxnW'(do_alloc) - TxnW'(do_ret);
        end
    end

    // Sticky status: reset request with its rising-edge interrupt, captured ID, overflow.
    always_ff @(posedge clk_i) begin
        if (rst_i || reset_clear_i) begin
            reset_req_o  <= 1'b0;
            irq_o        <= 1'b0;
            overflow_o   <= 1'b0;
            timeout_id_o <= '0;
        end else begin
            irq_o <= first_to;
            if (first_to) begin
                reset_req_o  <= 1'b1;
                timeout_id_o <= hit_id;
            end
            if (ar_hs && full) overflow_o <= 1'b1;
        end
    end

`ifdef READ_GUARD_PROT_CHECK_EN
    // Sticky flag for an R last beat that no outstanding read accounts for.
    always_ff @(posedge clk_i) begin
        if (rst_i || reset_clear_i) begin
            unmatched_o <= 1'b0;
        end else if (r_last_hs && !match) begin
            unmatched_o <= 1'b1;
        end
    end
`else
    assign unmatched_o = 1'b0;
`endif
endmodule

// File: doc/read_guard.md
READ_GUARD -- requirements
Module: read_guard

Interface
REQ-001 SHALL have parameter MaxRdTxns, default 8: number of outstanding-read tracking entries (>=1).
REQ-002 SHALL have parameter IdWidth, default 4: AXI read ID width.
REQ-003 SHALL have parameter CntWidth, default 12: per-entry cycle counter and budget width.
REQ-004 SHALL have ports: clk_i input 1, single clock; reset is synchronous and active-high: rst_i input 1.
REQ-005 SHALL have ports: ar_valid_i input 1; ar_ready_i input 1; ar_id_i input IdWidth; ar_len_i input 8, observed AR channel.
REQ-006 SHALL have ports: r_valid_i input 1; r_ready_i input 1; r_id_i input IdWidth; r_last_i input 1, observed R channel.
REQ-007 SHALL have ports: budget_ar_i input 8, AR valid-to-ready budget; budget_base_i input 8; budget_beat_i input 4.
REQ-008 SHALL have ports: reset_clear_i input 1; reset_req_o output 1; irq_o output 1; overflow_o output 1; unmatched_o output 1; txn_cnt_o output clog2(MaxRdTxns+1); timeout_id_o output IdWidth.

Function
REQ-009 SHALL allocate the lowest-index free entry on AR handshake (ar_valid_i & ar_ready_i), storing ar_id_i, counter 0, budget = budget_base_i + (ar_len_i+1)*budget_beat_i, saturated at 2^CntWidth-1.
REQ-010 SHALL increment each valid entry's counter by 1 every cycle after allocation, saturating at 2^CntWidth-1.
REQ-011 SHALL, on R handshake with r_last_i=1, free the valid entry with matching ID and largest counter (oldest); ties resolve to lowest index.
REQ-012 SHALL ignore R handshakes with r_last_i=0 for table state.
REQ-013 SHALL use registered table state for both allocate and retire decisions; same-cycle allocate and retire both take effect.
REQ-014 SHALL, when table full at AR handshake, not allocate and set overflow_o sticky, even if a retire occurs in the same cycle.
REQ-015 SHALL count consecutive cycles of ar_valid_i=1 & ar_ready_i=0 in an 8-bit stall counter, cleared on handshake or ar_valid_i=0.
REQ-016 SHALL detect timeout when any valid entry has counter > budget, or stall counter > budget_ar_i.
REQ-017 SHALL assert reset_req_o the cycle after timeout detection and hold it until reset_clear_i.
REQ-018 SHALL pulse irq_o for exactly one cycle coincident with the rising edge of reset_req_o.
REQ-019 SHALL capture in timeout_id_o the ID of the lowest-index timed-out entry (ar_id_i for AR stall) at the first timeout; hold until clear.
REQ-020 SHALL freeze all counters while reset_req_o=1.
REQ-021 SHALL, on reset_clear_i=1, free all entries and clear reset_req_o, overflow_o, unmatched_o, timeout_id_o, stall counter next cycle; clear wins over same-cycle timeout, allocate or retire.
REQ-022 SHALL drive txn_cnt_o as registered count of valid entries.

Reset
REQ-023 SHALL, on rst_i=1 at clock edge, free all entries and set reset_req_o, irq_o, overflow_o, unmatched_o, txn_cnt_o, timeout_id_o, stall counter to 0.
REQ-024 SHALL treat rst_i asserted mid-transaction as abandoning all tracking; no timeout raised for abandoned entries.

Configuration
REQ-025 SHALL, with macro READ_GUARD_PROT_CHECK_EN defined, set unmatched_o sticky on R handshake with r_last_i=1 and no valid entry matching r_id_i.
REQ-026 SHALL, without READ_GUARD_PROT_CHECK_EN, tie unmatched_o to 0 and silently ignore unmatched R last beats.

Verification
REQ-027 SHALL cover: AR id=3 len=3, base=10 beat=2 (budget 18), R last at cycle 15 -> entry freed, txn_cnt_o 1->0, reset_req_o stays 0.
REQ-028 SHALL cover: same AR with no R -> counter reaches 19, reset_req_o=1 next cycle, irq_o one-cycle pulse, timeout_id_o=3.
REQ-029 SHALL cover: two ARs id=5 then id=5, one R last id=5 -> older entry freed, txn_cnt_o=1, younger counter continues.
REQ-030 SHALL cover: MaxRdTxns ARs outstanding, extra AR handshake concurrent with R last -> overflow_o=1, txn_cnt_o=MaxRdTxns-1.
REQ-031 SHALL cover: ar_valid_i held with ar_ready_i=0, budget_ar_i=4 -> reset_req_o=1 after 6th stalled cycle; reset_clear_i -> all outputs 0.
REQ-032 SHALL cover: with READ_GUARD_PROT_CHECK_EN, R last id=7 with empty table -> unmatched_o=1; without macro -> unmatched_o=0.
